// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Optional build macro: MULDIV_EARLY_TERM_EN (see muldiv_sequencer).
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Single combinational iteration: shift-add multiply step or restoring divide step.
// Divide layout: acc = {partial remainder, quotient/dividend bits}.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    acc_next = {sum, acc[WIDTH-1:1]};
    // Remainder stays below the divisor, so it always fits back into WIDTH bits.
    if (is_div) begin
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MULU/DIV/DIVU unit: FSM, iteration counter and sign handling.
// Build macro MULDIV_EARLY_TERM_EN: multiplies finish early once the multiplier runs out of ones.
//
// state | meaning
// IDLE  | waiting for start_i; results held
// CALC  | one algorithm iteration per edge, counter runs down to 0
// FIX   | sign correction, load hi_o/lo_o/div_zero_o
// DONE  | done_o high for this cycle; start_i accepted back-to-back
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next, ld_acc, prod_fix;
  logic [WIDTH-1:0]   opnd, ld_opnd, abs1, abs2, quo_fix, rem_fix;
  logic               div_q, neg_res, neg_rem, dz;
  logic               ld_signed, ld_div, ld_dz, sgn1, sgn2;
  op_e                op_sel;

  always_comb begin
    op_sel    = op_e'(op_i);
    ld_signed = (op_sel == OP_MUL) || (op_sel == OP_DIV);
    ld_div    = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    sgn1      = ld_signed & data1_i[WIDTH-1];
    sgn2      = ld_signed & data2_i[WIDTH-1];
    abs1      = sgn1 ? -data1_i : data1_i;
    abs2      = sgn2 ? -data2_i : data2_i;
    ld_dz     = ld_div && (data2_i == '0);
    ld_opnd   = ld_div ? abs2 : abs1;
    // Divide-by-zero keeps the raw dividend so it can be returned unmodified.
    if (ld_dz)       ld_acc = {{WIDTH{1'b0}}, data1_i};
    else if (ld_div) ld_acc = {{WIDTH{1'b0}}, abs1};
    else             ld_acc = {{WIDTH{1'b0}}, abs2};
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .is_div   (div_q),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_next)
  );

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] et_mask;
  logic             et_hit;

  // Bits [cnt:0] of the low half are the multiplier bits not yet consumed.
  always_comb begin
    et_mask = ~({WIDTH{1'b1}} << (cnt + 1'b1));
    et_hit  = !div_q && ((acc[WIDTH-1:0] & et_mask) == '0);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      div_q      <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dz         <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            div_q      <= ld_div;
            acc        <= ld_acc;
            opnd       <= ld_opnd;
            neg_res    <= sgn1 ^ sgn2;
            neg_rem    <= sgn1;
            dz         <= ld_dz;
            div_zero_o <= 1'b0;
            busy_o     <= 1'b1;
            // Divide-by-zero spends one idle CALC slot so its latency is fixed at two edges to DONE.
            cnt        <= ld_dz ? '0 : CNT_LAST;
            state      <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (!dz) acc <= acc_next;
          if (cnt == '0) state <= FIX;
          else           cnt <= cnt - 1'b1;
`ifdef MULDIV_EARLY_TERM_EN
          if (et_hit) begin
            acc   <= acc >> (cnt + 1'b1);
            state <= FIX;
          end
`endif
        end
        FIX: begin
          if (dz) begin
            lo_o <= '1;
            hi_o <= acc[WIDTH-1:0];
          end else if (div_q) begin
            lo_o <= quo_fix;
            hi_o <= rem_fix;
          end else begin
            {hi_o, lo_o} <= prod_fix;
          end
          div_zero_o <= dz;
          busy_o     <= 1'b0;
          done_o     <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic reference model checked every cycle,
// plus hand-computed literal results and latencies.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'd0;
  logic [W-1:0]  data1_i = '0;
  logic [W-1:0]  data2_i = '0;
  logic          busy_o, done_o, div_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: an accepted op completes a fixed number of edges later.
  int          left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0;

  task automatic model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sx, sy;
    longint unsigned ux, uy;
    p_dz = 0;
    case (op)
      2'd0: begin
        sx = longint'($signed(a)) * longint'($signed(b));
        {p_hi, p_lo} = sx;
      end
      2'd1: begin
        ux = longint'({32'b0, a}) * longint'({32'b0, b});
        {p_hi, p_lo} = ux;
      end
      default: begin
        if (b == '0) begin
          p_dz = 1;
          p_lo = '1;
          p_hi = a;
        end else if (op == 2'd2) begin
          sx = longint'($signed(a));
          sy = longint'($signed(b));
          p_lo = W'(sx / sy);
          p_hi = W'(sx % sy);
        end else begin
          ux = longint'({32'b0, a});
          uy = longint'({32'b0, b});
          p_lo = W'(ux / uy);
          p_hi = W'(ux % uy);
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      left = 0; m_busy = 0; m_done = 0; m_hi = '0; m_lo = '0; m_dz = 0;
    end else begin
      m_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_done = 1; m_busy = 0; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
        end
      end else if (start_i) begin
        model_op(op_i, data1_i, data2_i);
        left   = p_dz ? 2 : W + 1;
        m_busy = 1;
        m_dz   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(busy_o), 64'(m_busy));
      chk("cyc_done", 64'(done_o), 64'(m_done));
      chk("cyc_hi", 64'(hi_o), 64'(m_hi));
      chk("cyc_lo", 64'(lo_o), 64'(m_lo));
      chk("cyc_dz", 64'(div_zero_o), 64'(m_dz));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 100);
    chk("wait_done", 64'(done_o), 64'd1);
  endtask

  // Latency returned = edges from the accepting edge until done_o is visible.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk); #1;
    start_i = 1'b1; op_i = op; data1_i = a; data2_i = b;
    @(negedge clk); #1;
    start_i = 1'b0;
    wait_done(lat);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
    int           lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [0:NV-1] = '{
    '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33},
    '{2'd0, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 33},
    '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33},
    '{2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 2},
    '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33},
    '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33},
    '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33},
    '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33},
    '{2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33},
    '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33},
    '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, g;
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    chk("rst_dz", 64'(div_zero_o), 64'd0);
    chk_en = 1'b1;
    #1 rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_hi", i), 64'(hi_o), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo_o), 64'(vecs[i].lo));
      chk($sformatf("v%0d_dz", i), 64'(div_zero_o), 64'(vecs[i].dz));
      chk($sformatf("v%0d_model_hi", i), 64'(m_hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d_model_lo", i), 64'(m_lo), 64'(vecs[i].lo));
    end

    // Back-to-back: start held through DONE, then a stray pulse mid-CALC.
    @(negedge clk); #1;
    start_i = 1'b1; op_i = 2'd3; data1_i = 32'd17; data2_i = 32'd5;
    wait_done(g);
    chk("b2b_first_lat", 64'(g - 1), 64'd33);
    chk("b2b_first_hi", 64'(hi_o), 64'd2);
    chk("b2b_first_lo", 64'(lo_o), 64'd3);
    #1;
    op_i = 2'd1; data1_i = 32'd3; data2_i = 32'd4;
    g = 0;
    do begin
      @(negedge clk);
      g++;
      if (g == 1)  begin #1 start_i = 1'b0; end
      if (g == 10) begin #1 start_i = 1'b1; op_i = 2'd2; data1_i = 32'd9; data2_i = 32'd3; end
      if (g == 11) begin #1 start_i = 1'b0; end
    end while (!done_o && g < 100);
    chk("b2b_second_done", 64'(done_o), 64'd1);
    chk("b2b_second_lat", 64'(g - 1), 64'd33);
    chk("b2b_second_hi", 64'(hi_o), 64'd0);
    chk("b2b_second_lo", 64'(lo_o), 64'd12);

    // Reset part-way through an operation.
    @(negedge clk); #1;
    start_i = 1'b1; op_i = 2'd1; data1_i = 32'h1234_5678; data2_i = 32'd9;
    @(negedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_before", 64'(busy_o), 64'd1);
    #1 rst_i = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_done", 64'(done_o), 64'd0);
    chk("mid_rst_hi", 64'(hi_o), 64'd0);
    chk("mid_rst_lo", 64'(lo_o), 64'd0);
    repeat (3) @(negedge clk);
    #1 rst_i = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_done", 64'(done_o), 64'd0);
    do_op(2'd1, 32'd2, 32'd3, lat);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_hi", 64'(hi_o), 64'd0);
    chk("post_rst_lo", 64'(lo_o), 64'd6);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
